// File: rtl/fetch_queue_stage.sv
// ----------------------------------------------------------------------------
// fetch_queue_stage
//
// Instruction-fetch stage with a small decoupling queue. Owns the fetch PC,
// presents pc_F/pc4 to the branch predictor and instruction memory, and
// captures each fetched {pc, pc+4, instr, predicted-taken} tuple into a
// DEPTH-entry FIFO. Decode consumes from the FIFO head, so a decode stall
// only freezes fetch once the queue has filled. An EX redirect (flush)
// reloads the PC from pc_restore and discards every queued entry.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   pc_next      in   32  predicted next PC from branch predictor
//   taken_F      in   1   predictor marks current pc_F as taken
//   pc_restore   in   32  redirect target from EX (qualified by flush)
//   flush        in   1   EX mispredict / jump redirect
//   instr_F      in   32  instruction word at pc_F (combinational imem read)
//   imem_valid   in   1   instr_F valid this cycle
//   stall_D      in   1   decode cannot accept the head this cycle
//   pc_F         out  32  current fetch PC (registered)
//   pc4          out  32  pc_F + 4
//   fetch_stall  out  1   fetch cannot push this cycle (full, no pop)
//   valid_D      out  1   queue head valid
//   instr_D      out  32  head instruction, NOP when empty
//   pc_D         out  32  head PC, 0 when empty
//   pc4_D        out  32  head PC+4, 0 when empty
//   taken_D      out  1   head predicted-taken bit, 0 when empty
// ----------------------------------------------------------------------------
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        taken_F,
  input  logic [31:0] pc_restore,
  input  logic        flush,
  input  logic [31:0] instr_F,
  input  logic        imem_valid,
  input  logic        stall_D,
  output logic [31:0] pc_F,
  output logic [31:0] pc4,
  output logic        fetch_stall,
  output logic        valid_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        taken_D
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Fetch PC and queue bookkeeping.
  logic [31:0]      pc_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Queue storage, one array per tuple field.
  logic [31:0] pc_mem_r    [DEPTH];
  logic [31:0] pc4_mem_r   [DEPTH];
  logic [31:0] instr_mem_r [DEPTH];
  logic        taken_mem_r [DEPTH];

  logic [31:0]      pc4_s;
  logic             valid_s;
  logic             pop_s;
  logic             push_s;
  logic             fetch_stall_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [31:0]      instr_head_s;
  logic [31:0]      pc_head_s;
  logic [31:0]      pc4_head_s;
  logic             taken_head_s;

  // PCs are word aligned; the low two bits of the incoming targets are dropped.
  logic unused_bits_s;
  assign unused_bits_s = ^{pc_next[1:0], pc_restore[1:0]};

  assign pc4_s   = pc_r + 32'd4;
  assign valid_s = (count_r != {CNT_W{1'b0}});

  // Handshake: a flush cycle neither pops nor pushes. When full, a push is
  // only accepted alongside a pop so the slot being freed is reused at once.
  always_comb begin
    pop_s         = valid_s & ~stall_D & ~flush;
    push_s        = imem_valid & ~flush & ((count_r < DEPTH_C) | pop_s);
    fetch_stall_s = (count_r == DEPTH_C) & ~pop_s;
  end

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch PC, pointers and count; flush outranks a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= {RESET_PC[31:2], 2'b00};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      pc_r     <= {pc_restore[31:2], 2'b00};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_r     <= {pc_next[31:2], 2'b00};
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Queue storage write; entries are cleared on reset so no stale data remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        pc4_mem_r[i]   <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
        taken_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= pc_r;
      pc4_mem_r[wr_ptr_r]   <= pc4_s;
      instr_mem_r[wr_ptr_r] <= instr_F;
      taken_mem_r[wr_ptr_r] <= taken_F;
    end
  end

  // Head view: the entry at rd_ptr when valid, otherwise a NOP bubble.
  always_comb begin
    if (valid_s) begin
      instr_head_s = instr_mem_r[rd_ptr_r];
      pc_head_s    = pc_mem_r[rd_ptr_r];
      pc4_head_s   = pc4_mem_r[rd_ptr_r];
      taken_head_s = taken_mem_r[rd_ptr_r];
    end else begin
      instr_head_s = NOP;
      pc_head_s    = 32'h0000_0000;
      pc4_head_s   = 32'h0000_0000;
      taken_head_s = 1'b0;
    end
  end

  assign pc_F        = pc_r;
  assign pc4         = pc4_s;
  assign fetch_stall = fetch_stall_s;
  assign valid_D     = valid_s;
  assign instr_D     = instr_head_s;
  assign pc_D        = pc_head_s;
  assign pc4_D       = pc4_head_s;
  assign taken_D     = taken_head_s;

endmodule
